// File: rtl/traffic_light_ctrl_param_if.sv
// Lamp/sensor bundle between the intersection top level and the light controller.
// The controller uses the slave view; whoever drives sensors and timebase uses master.
interface traffic_light_ctrl_param_if;
    logic       tick_en;
    logic       C;
    logic       ped_req;
    logic       emerg;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic       ped_walk;
    logic [2:0] state_o;

    modport master (
        output tick_en,
        output C,
        output ped_req,
        output emerg,
        input  light_highway,
        input  light_farm,
        input  ped_walk,
        input  state_o
    );

    modport slave (
        input  tick_en,
        input  C,
        input  ped_req,
        input  emerg,
        output light_highway,
        output light_farm,
        output ped_walk,
        output state_o
    );
endinterface

// File: rtl/traffic_light_ctrl_param.sv
// Highway/farm-road light controller with tick-based phase timer, latched pedestrian
// demand, all-red clearance and emergency all-red override. Lamps are registered off the state.
module traffic_light_ctrl_param #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned HW_GREEN_MIN   = 8,
    parameter int unsigned FARM_GREEN_MAX = 6,
    parameter int unsigned YELLOW_T       = 3,
    parameter int unsigned ALL_RED_T      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    traffic_light_ctrl_param_if.slave   bus
);

    localparam logic [CNT_W-1:0] L_HW_MIN_LAST = CNT_W'(HW_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] L_FM_MAX_LAST = CNT_W'(FARM_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] L_YEL_LAST    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] L_AR_LAST     = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] L_TMR_MAX     = '1;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [2:0] {
        S_HW_G   = 3'd0,
        S_HW_Y   = 3'd1,
        S_RED1   = 3'd2,
        S_FM_G   = 3'd3,
        S_FM_Y   = 3'd4,
        S_RED2   = 3'd5,
        S_EMERG  = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic             r_ped_pend;

    logic [2:0]       r_light_hw;
    logic [2:0]       r_light_fm;
    logic             r_ped_walk;
    logic [2:0]       r_state_o;

    logic [2:0]       w_light_hw;
    logic [2:0]       w_light_fm;
    logic             w_ped_walk;

    logic             w_tick;
    logic             w_hw_min_done;
    logic             w_fm_max_exp;
    logic             w_yel_exp;
    logic             w_ar_exp;
    logic             w_timer_clr;
    logic             w_fm_entry;

    assign w_tick        = bus.tick_en;
    assign w_hw_min_done = w_tick && (r_timer >= L_HW_MIN_LAST);
    assign w_fm_max_exp  = w_tick && (r_timer == L_FM_MAX_LAST);
    assign w_yel_exp     = w_tick && (r_timer == L_YEL_LAST);
    assign w_ar_exp      = w_tick && (r_timer == L_AR_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HW_G;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and lamp decode; emergency overrides every phase
    always_comb begin
        w_next     = r_state;
        w_light_hw = LAMP_RED;
        w_light_fm = LAMP_RED;
        w_ped_walk = 1'b0;

        case (r_state)
            S_HW_G: begin
                w_light_hw = LAMP_GRN;
                if (w_hw_min_done && (bus.C || r_ped_pend)) begin
                    w_next = S_HW_Y;
                end
            end
            S_HW_Y: begin
                w_light_hw = LAMP_YEL;
                if (w_yel_exp) begin
                    w_next = S_RED1;
                end
            end
            S_RED1: begin
                if (w_ar_exp) begin
                    w_next = S_FM_G;
                end
            end
            S_FM_G: begin
                w_light_fm = LAMP_GRN;
                w_ped_walk = 1'b1;
                if ((w_tick && !bus.C) || w_fm_max_exp) begin
                    w_next = S_FM_Y;
                end
            end
            S_FM_Y: begin
                w_light_fm = LAMP_YEL;
                if (w_yel_exp) begin
                    w_next = S_RED2;
                end
            end
            S_RED2: begin
                if (w_ar_exp) begin
                    w_next = S_HW_G;
                end
            end
            S_EMERG: begin
                w_next = S_RED2;
            end
            default: begin
                w_next = S_RED2;
            end
        endcase

        if (bus.emerg) begin
            w_next = S_EMERG;
        end
    end

    assign w_timer_clr = bus.emerg || (w_next != r_state);
    assign w_fm_entry  = (w_next == S_FM_G) && (r_state != S_FM_G);

    // Phase timer: restarts on every phase change, saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else if (w_tick && (r_timer != L_TMR_MAX)) begin
            r_timer <= r_timer + CNT_W'(1);
        end
    end

    // Pedestrian demand latch; entering farm green consumes it even if a new request coincides
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ped_pend <= 1'b0;
        end else if (w_fm_entry) begin
            r_ped_pend <= 1'b0;
        end else if (bus.ped_req) begin
            r_ped_pend <= 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_light_hw <= LAMP_GRN;
            r_light_fm <= LAMP_RED;
            r_ped_walk <= 1'b0;
            r_state_o  <= 3'd0;
        end else begin
            r_light_hw <= w_light_hw;
            r_light_fm <= w_light_fm;
            r_ped_walk <= w_ped_walk;
            r_state_o  <= r_state;
        end
    end

    assign bus.light_highway = r_light_hw;
    assign bus.light_farm    = r_light_fm;
    assign bus.ped_walk      = r_ped_walk;
    assign bus.state_o       = r_state_o;

    // Conflicting greens/yellows must never reach the lamps
    a_no_conflict: assert property (@(posedge clk) disable iff (!rst_n)
        (r_light_hw == LAMP_RED) || (r_light_fm == LAMP_RED));

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench for traffic_light_ctrl_param: per-cycle scoreboard against a phase model
// plus per-scenario phase-length and signal checks.
module tb_traffic_light_ctrl_param;

    localparam int HW_MIN = 8;
    localparam int FM_MAX = 6;
    localparam int YEL    = 3;
    localparam int AR     = 2;

    typedef struct {
        int st;
        int len;
    } run_t;

    logic clk;
    logic rst_n;

    traffic_light_ctrl_param_if tif();

    traffic_light_ctrl_param #(
        .CNT_W(8), .HW_GREEN_MIN(HW_MIN), .FARM_GREEN_MAX(FM_MAX),
        .YELLOW_T(YEL), .ALL_RED_T(AR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (tif)
    );

    int         n_checks;
    int         n_fail;
    bit         sb_en;
    logic [9:0] sb_q[$];
    logic [9:0] mon_exp;
    logic [9:0] mon_act;

    int   m_st;
    int   m_tmr;
    bit   m_pend;

    run_t runs_q[$];
    int   cur_st;
    int   cur_len;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] dec(input int s);
        case (s)
            0:       dec = {3'b001, 3'b100, 1'b0, 3'd0};
            1:       dec = {3'b010, 3'b100, 1'b0, 3'd1};
            2:       dec = {3'b100, 3'b100, 1'b0, 3'd2};
            3:       dec = {3'b100, 3'b001, 1'b1, 3'd3};
            4:       dec = {3'b100, 3'b010, 1'b0, 3'd4};
            5:       dec = {3'b100, 3'b100, 1'b0, 3'd5};
            default: dec = {3'b100, 3'b100, 1'b0, 3'd6};
        endcase
    endfunction

    // Scoreboard consumer: one expected output word per clock edge
    always @(posedge clk) begin
        #1;
        if (sb_en && sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_act = {tif.light_highway, tif.light_farm, tif.ped_walk, tif.state_o};
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL sb_outputs t=%0t got=%b expected=%b", $time, mon_act, mon_exp);
            end
            n_checks++;
            if ((tif.light_highway !== 3'b100) && (tif.light_farm !== 3'b100)) begin
                n_fail++;
                $display("FAIL lamp_conflict t=%0t got hw=%b fm=%b expected one red",
                         $time, tif.light_highway, tif.light_farm);
            end
        end
    end

    // Called at a falling edge: apply inputs for the next rising edge, step model, push expectation
    task automatic drive(input bit t, input bit c, input bit p, input bit e);
        int n;
        tif.tick_en = t;
        tif.C       = c;
        tif.ped_req = p;
        tif.emerg   = e;
        if (sb_en) sb_q.push_back(dec(m_st));
        n = m_st;
        if (e) n = 6;
        else begin
            case (m_st)
                0: if (t && m_tmr >= HW_MIN - 1 && (c || m_pend)) n = 1;
                1: if (t && m_tmr == YEL - 1) n = 2;
                2: if (t && m_tmr == AR - 1) n = 3;
                3: if (t && (!c || m_tmr == FM_MAX - 1)) n = 4;
                4: if (t && m_tmr == YEL - 1) n = 5;
                5: if (t && m_tmr == AR - 1) n = 0;
                default: n = 5;
            endcase
        end
        if (n == 3 && m_st != 3) m_pend = 1'b0;
        else if (p) m_pend = 1'b1;
        if (e || n != m_st) m_tmr = 0;
        else if (t && m_tmr < 255) m_tmr++;
        m_st = n;
        @(negedge clk);
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        sb_q.delete();
        tif.tick_en = 1'b0;
        tif.C       = 1'b0;
        tif.ped_req = 1'b0;
        tif.emerg   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_st   = 0;
        m_tmr  = 0;
        m_pend = 1'b0;
        sb_en  = 1'b1;
    endtask

    task automatic trk_init();
        runs_q.delete();
        cur_st  = int'(tif.state_o);
        cur_len = 1;
    endtask

    task automatic track();
        if (int'(tif.state_o) == cur_st) cur_len++;
        else begin
            runs_q.push_back('{cur_st, cur_len});
            cur_st  = int'(tif.state_o);
            cur_len = 1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (tif.light_highway !== 3'b001) begin n_fail++; $display("FAIL reset_hw got=%b expected=001", tif.light_highway); end
        n_checks++;
        if (tif.light_farm !== 3'b100) begin n_fail++; $display("FAIL reset_fm got=%b expected=100", tif.light_farm); end
        n_checks++;
        if (tif.ped_walk !== 1'b0) begin n_fail++; $display("FAIL reset_walk got=%b expected=0", tif.ped_walk); end
        n_checks++;
        if (tif.state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d expected=0", tif.state_o); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (tif.state_o !== 3'd0 || tif.light_highway !== 3'b001) begin
                n_fail++;
                $display("FAIL idle_hold cyc=%0d got state=%0d hw=%b expected state=0 hw=001", i, tif.state_o, tif.light_highway);
            end
        end
    endtask

    task automatic test_full_cycle();
        int exp_st[7]  = '{1, 2, 3, 4, 5, 0, 1};
        int exp_len[7] = '{YEL, AR, FM_MAX, YEL, AR, HW_MIN, YEL};
        do_reset();
        trk_init();
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, i >= 2, 1'b0, 1'b0);
            track();
        end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (runs_q.size() < k + 2) begin
                n_fail++;
                $display("FAIL cycle_run%0d got=missing expected st=%0d len=%0d", k, exp_st[k], exp_len[k]);
            end else if (runs_q[k+1].st != exp_st[k] || runs_q[k+1].len != exp_len[k]) begin
                n_fail++;
                $display("FAIL cycle_run%0d got st=%0d len=%0d expected st=%0d len=%0d",
                         k, runs_q[k+1].st, runs_q[k+1].len, exp_st[k], exp_len[k]);
            end
        end
    endtask

    task automatic test_c_drop();
        int guard = 0;
        bit found = 1'b0;
        do_reset();
        trk_init();
        while (m_st != 3 && guard < 60) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            track();
            guard++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0); track();
        drive(1'b1, 1'b1, 1'b0, 1'b0); track();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            track();
        end
        for (int k = 0; k + 1 < runs_q.size(); k++) begin
            if (runs_q[k].st == 3 && !found) begin
                found = 1'b1;
                n_checks++;
                if (runs_q[k].len != 3 || runs_q[k+1].st != 4) begin
                    n_fail++;
                    $display("FAIL c_drop_fmg got len=%0d next=%0d expected len=3 next=4", runs_q[k].len, runs_q[k+1].st);
                end
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL c_drop_seen got=no_fm_g expected=fm_g_run"); end
    endtask

    task automatic test_ped();
        int walk_cnt = 0;
        int exp_st[5]  = '{1, 2, 3, 4, 5};
        int exp_len[5] = '{YEL, AR, 1, YEL, AR};
        do_reset();
        trk_init();
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, 1'b0, i == 1, 1'b0);
            track();
            if (tif.ped_walk === 1'b1) walk_cnt++;
            n_checks++;
            if (tif.ped_walk !== (tif.state_o == 3'd3)) begin
                n_fail++;
                $display("FAIL ped_walk cyc=%0d got walk=%b state=%0d expected walk=(state==3)", i, tif.ped_walk, tif.state_o);
            end
        end
        n_checks++;
        if (walk_cnt != 1) begin n_fail++; $display("FAIL ped_walk_len got=%0d expected=1", walk_cnt); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (runs_q.size() < k + 2 || runs_q[k+1].st != exp_st[k] || runs_q[k+1].len != exp_len[k]) begin
                n_fail++;
                $display("FAIL ped_run%0d got runs=%0d expected st=%0d len=%0d", k, runs_q.size(), exp_st[k], exp_len[k]);
            end
        end
        n_checks++;
        if (cur_st != 0 || cur_len < 30) begin
            n_fail++;
            $display("FAIL ped_rearm got st=%0d len=%0d expected st=0 len>=30", cur_st, cur_len);
        end
    endtask

    task automatic test_emerg();
        int guard = 0;
        do_reset();
        while (m_st != 3 && guard < 60) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (tif.state_o !== 3'd6 || tif.light_highway !== 3'b100 || tif.light_farm !== 3'b100 || tif.ped_walk !== 1'b0) begin
            n_fail++;
            $display("FAIL emerg_hold got st=%0d hw=%b fm=%b walk=%b expected st=6 hw=100 fm=100 walk=0",
                     tif.state_o, tif.light_highway, tif.light_farm, tif.ped_walk);
        end
        trk_init();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            track();
        end
        n_checks++;
        if (runs_q.size() < 2 || runs_q[1].st != 5 || runs_q[1].len != AR || cur_st != 0) begin
            n_fail++;
            $display("FAIL emerg_release got runs=%0d cur=%0d expected RED2 for %0d then HW_G", runs_q.size(), cur_st, AR);
        end
    endtask

    task automatic test_slow_tick();
        int cyc = 0;
        int guard = 0;
        int exp_st[6]  = '{1, 2, 3, 4, 5, 0};
        int exp_len[6] = '{4*YEL, 4*AR, 4*FM_MAX, 4*YEL, 4*AR, 4*HW_MIN};
        do_reset();
        trk_init();
        for (int i = 0; i < 150; i++) begin
            drive((cyc % 4) == 3, 1'b1, 1'b0, 1'b0);
            track();
            cyc++;
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (runs_q.size() < k + 2 || runs_q[k+1].st != exp_st[k] || runs_q[k+1].len != exp_len[k]) begin
                n_fail++;
                $display("FAIL slow_run%0d got runs=%0d expected st=%0d len=%0d", k, runs_q.size(), exp_st[k], exp_len[k]);
            end
        end
        while (tif.state_o !== 3'd1 && guard < 200) begin
            drive((cyc % 4) == 3, 1'b1, 1'b0, 1'b0);
            cyc++;
            guard++;
        end
        drive((cyc % 4) == 3, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (tif.state_o !== 3'd1 || tif.light_highway !== 3'b010) begin
            n_fail++;
            $display("FAIL slow_pre_reset got st=%0d hw=%b expected st=1 hw=010", tif.state_o, tif.light_highway);
        end
        #2;
        sb_en = 1'b0;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tif.light_highway !== 3'b001 || tif.light_farm !== 3'b100 || tif.state_o !== 3'd0 || tif.ped_walk !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got hw=%b fm=%b st=%0d walk=%b expected hw=001 fm=100 st=0 walk=0",
                     tif.light_highway, tif.light_farm, tif.state_o, tif.ped_walk);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        m_st   = 0;
        m_tmr  = 0;
        m_pend = 1'b0;
        sb_en  = 1'b1;
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (tif.state_o !== 3'd0) begin n_fail++; $display("FAIL post_reset_hold got=%0d expected=0", tif.state_o); end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        sb_en       = 1'b0;
        rst_n       = 1'b0;
        tif.tick_en = 1'b0;
        tif.C       = 1'b0;
        tif.ped_req = 1'b0;
        tif.emerg   = 1'b0;
        test_reset();
        test_idle();
        test_full_cycle();
        test_c_drop();
        test_ped();
        test_emerg();
        test_slow_tick();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl_param.md
Name: traffic_light_ctrl_param

Overview:
- Parametrised successor to the highway/farm-road traffic light controller.
- Programmable phase durations counted in prescaled ticks.
- Adds a latched pedestrian request, an emergency all-red override, an all-red clearance phase and a phase-state output.
- Sits at the intersection top level and drives the two 3-bit lamp buses directly.

Parameters:
- CNT_W, 8: width of the phase timer in bits. Every duration below must be ≤ 2^CNT_W−1.
- HW_GREEN_MIN, 8: minimum highway green, in ticks (≥1).
- FARM_GREEN_MAX, 6: maximum farm-road green, in ticks (≥1).
- YELLOW_T, 3: yellow duration for both roads, in ticks (≥1).
- ALL_RED_T, 2: all-red clearance duration, in ticks (≥1).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- tick_en, input, 1: timebase strobe; the timer advances only on cycles where it is 1.
- C, input, 1: farm-road vehicle sensor, level.
- ped_req, input, 1: pedestrian crossing request (for the farm road), pulse or level.
- emerg, input, 1: emergency override, level.
- light_highway, output, 3: highway lamps. 3'b100 = red, 3'b010 = yellow, 3'b001 = green.
- light_farm, output, 3: farm-road lamps, same encoding.
- ped_walk, output, 1: walk signal for crossing the highway.
- state_o, output, 3: current phase code.

Behaviour:
- Phases and codes: HW_G=0, HW_Y=1, RED1=2, FM_G=3, FM_Y=4, RED2=5, EMERG=6.
- Lamps per phase (highway/farm):
  - HW_G: green/red.
  - HW_Y: yellow/red.
  - RED1, RED2, EMERG: red/red.
  - FM_G: red/green.
  - FM_Y: red/yellow.
- All outputs are registered and decoded from the state register; lamps change 1 cycle after the state transition decision.
- Reset values: state HW_G, light_highway=3'b001, light_farm=3'b100, ped_walk=0, state_o=0, timer=0, ped_pend=0.
- Timer:
  - Cleared to 0 on every state change.
  - Otherwise increments on tick_en, saturating at all-ones.
  - "Expired(D)" means tick_en=1 and timer==D−1 in the same cycle.
- ped_pend:
  - Set on any cycle with ped_req=1.
  - Cleared on the cycle the FSM enters FM_G; entry wins over a simultaneous ped_req.
- Transitions (evaluated each clk; EMERG has the highest priority):
  - Any state, emerg=1: go to EMERG next cycle. Timer cleared. ped_pend is retained.
  - EMERG, emerg=0: go to RED2.
  - HW_G: go to HW_Y when tick_en=1 and timer ≥ HW_GREEN_MIN−1 and (C or ped_pend). Otherwise hold; highway green is indefinite with no demand.
  - HW_Y: go to RED1 on Expired(YELLOW_T).
  - RED1: go to FM_G on Expired(ALL_RED_T).
  - FM_G: go to FM_Y on tick_en=1 when C=0, or on Expired(FARM_GREEN_MAX), whichever comes first.
  - FM_Y: go to RED2 on Expired(YELLOW_T).
  - RED2: go to HW_G on Expired(ALL_RED_T).
- ped_walk=1 only while in FM_G.
- Safety invariant: light_highway and light_farm are never both non-red in any cycle.
- Unused state code 7: recovers to RED2 on the next cycle.
- Reset mid-phase: lamps return to the reset values immediately (asynchronously); ped_pend is lost.

Test Plan:
- Reset, tick_en=1 every cycle, C=0, ped_req=0 for 50 cycles → remains HW_G (001/100), state_o=0 throughout.
- C=1 from cycle 2 → HW_Y once timer reaches 7 (8 ticks), lasts 3 ticks, RED1 lasts 2, then FM_G (100/001); with C held, FM_Y after 6 ticks, then RED2 for 2, back to HW_G.
- During FM_G drop C after 2 ticks → FM_Y on the next tick; confirm FM_G lasted 3 ticks and no lamp overlap.
- C=0, one-cycle ped_req pulse at cycle 1 → after 8 ticks the full cycle runs; ped_walk=1 exactly while state_o=3; ped_pend cleared so the next HW_G holds indefinitely.
- emerg=1 mid-FM_G → next cycle state_o=6, both lamps 100, ped_walk=0; release → RED2 for 2 ticks, then HW_G.
- tick_en every 4th cycle, C=1 → all phase lengths scale ×4 in cycles. rst_n pulsed low mid-HW_Y → lamps 001/100 immediately, without waiting for a clk edge.
